// File: rtl/lcd_clock_display_if.sv
// Write-only HD44780 character LCD bus (8-bit mode).
// The master drives the bus; the panel side is the slave.
interface lcd_clock_display_if;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_data;

  modport master (
    output lcd_e,
    output lcd_rs,
    output lcd_rw,
    output lcd_data
  );

  modport slave (
    input lcd_e,
    input lcd_rs,
    input lcd_rw,
    input lcd_data
  );
endinterface

// File: rtl/lcd_clock_display.sv
// Shows binary hour/min/sec as "HH:MM:SS" on line 1 of an HD44780 LCD.
// All bus timing is counted in clock cycles; a frame is rewritten only when the time changes.
module lcd_clock_display #(
  parameter int E_PULSE    = 12,
  parameter int CMD_WAIT   = 2000,
  parameter int CLR_WAIT   = 82000,
  parameter int PWRUP_WAIT = 750000
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [5:0]                  sec,
  input  logic [5:0]                  min,
  input  logic [5:0]                  hour,
  output logic                        busy,
  lcd_clock_display_if.master         lcd
);

  localparam int MAX_AB   = (PWRUP_WAIT > CLR_WAIT) ? PWRUP_WAIT : CLR_WAIT;
  localparam int MAX_CD   = (CMD_WAIT > E_PULSE) ? CMD_WAIT : E_PULSE;
  localparam int MAX_WAIT = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW       = $clog2(MAX_WAIT + 1);

  localparam logic [CW-1:0] PWR_LAST = CW'(PWRUP_WAIT - 1);
  localparam logic [CW-1:0] E_LAST   = CW'(E_PULSE - 1);
  localparam logic [CW-1:0] CMD_LAST = CW'(CMD_WAIT - 1);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_WAIT - 1);

  typedef enum logic [2:0] {
    PWRUP,
    INIT,
    IDLE,
    ADDR,
    CHARS
  } state_t;

  typedef enum logic [1:0] {
    PH_SETUP,
    PH_PULSE,
    PH_WAIT
  } phase_t;

  state_t         state_reg, state_next;
  phase_t         phase_reg, phase_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [2:0]     idx_reg, idx_next;
  logic           shown_reg, shown_next;
  logic [17:0]    snap_reg;
  logic           snap_load;

  logic           e_reg;
  logic           rs_reg;
  logic [7:0]     data_reg;

  logic           wr_start;
  logic           byte_rs;
  logic [7:0]     byte_val;
  logic [CW-1:0]  wait_last;
  logic [17:0]    time_now;

  logic [7:0]     tens_chr [3];
  logic [7:0]     ones_chr [3];

  function automatic logic [3:0] tens_of(input logic [5:0] v);
    if (v >= 6'd60)      return 4'd6;
    else if (v >= 6'd50) return 4'd5;
    else if (v >= 6'd40) return 4'd4;
    else if (v >= 6'd30) return 4'd3;
    else if (v >= 6'd20) return 4'd2;
    else if (v >= 6'd10) return 4'd1;
    else                 return 4'd0;
  endfunction

  // The remainder is below 10, so 4-bit wrap-around arithmetic gives it exactly.
  function automatic logic [3:0] ones_of(input logic [5:0] v);
    logic [3:0] t;
    t = tens_of(v);
    return v[3:0] - (t * 4'd10);
  endfunction

  assign time_now = {hour, min, sec};

  // Index 0 = seconds, 1 = minutes, 2 = hours within the snapshot.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_digits
      logic [5:0] field;
      assign field        = snap_reg[6*gi +: 6];
      assign tens_chr[gi] = 8'h30 + {4'h0, tens_of(field)};
      assign ones_chr[gi] = 8'h30 + {4'h0, ones_of(field)};
    end
  endgenerate

  // Clear display needs the long settle time; the byte on the bus identifies it.
  assign wait_last = (!rs_reg && data_reg == 8'h01) ? CLR_LAST : CMD_LAST;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= PWRUP;
      phase_reg <= PH_SETUP;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shown_reg <= 1'b0;
      snap_reg  <= '0;
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shown_reg <= shown_next;
      if (snap_load) begin
        snap_reg <= time_now;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    shown_next = shown_reg;
    snap_load  = 1'b0;

    case (state_reg)
      PWRUP: begin
        if (cnt_reg == PWR_LAST) begin
          state_next = INIT;
          phase_next = PH_SETUP;
          cnt_next   = '0;
          idx_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      IDLE: begin
        if (!shown_reg || time_now != snap_reg) begin
          snap_load  = 1'b1;
          state_next = ADDR;
          phase_next = PH_SETUP;
          cnt_next   = '0;
          idx_next   = '0;
        end
      end

      INIT, ADDR, CHARS: begin
        case (phase_reg)
          PH_SETUP: begin
            phase_next = PH_PULSE;
            cnt_next   = '0;
          end
          PH_PULSE: begin
            if (cnt_reg == E_LAST) begin
              phase_next = PH_WAIT;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + CW'(1);
            end
          end
          default: begin
            if (cnt_reg == wait_last) begin
              phase_next = PH_SETUP;
              cnt_next   = '0;
              case (state_reg)
                INIT: begin
                  if (idx_reg == 3'd5) begin
                    state_next = IDLE;
                    idx_next   = '0;
                  end else begin
                    idx_next = idx_reg + 3'd1;
                  end
                end
                ADDR: begin
                  state_next = CHARS;
                  idx_next   = '0;
                end
                default: begin
                  if (idx_reg == 3'd7) begin
                    state_next = IDLE;
                    shown_next = 1'b1;
                    idx_next   = '0;
                  end else begin
                    idx_next = idx_reg + 3'd1;
                  end
                end
              endcase
            end else begin
              cnt_next = cnt_reg + CW'(1);
            end
          end
        endcase
      end

      default: begin
        state_next = PWRUP;
        phase_next = PH_SETUP;
        cnt_next   = '0;
        idx_next   = '0;
      end
    endcase
  end

  // Byte for the transaction about to start, selected from the upcoming state/index.
  always_comb begin
    byte_rs  = 1'b0;
    byte_val = 8'h00;
    case (state_next)
      INIT: begin
        case (idx_next)
          3'd0, 3'd1, 3'd2: byte_val = 8'h38;
          3'd3:             byte_val = 8'h0C;
          3'd4:             byte_val = 8'h01;
          default:          byte_val = 8'h06;
        endcase
      end
      ADDR: byte_val = 8'h80;
      CHARS: begin
        byte_rs = 1'b1;
        case (idx_next)
          3'd0:    byte_val = tens_chr[2];
          3'd1:    byte_val = ones_chr[2];
          3'd2:    byte_val = 8'h3A;
          3'd3:    byte_val = tens_chr[1];
          3'd4:    byte_val = ones_chr[1];
          3'd5:    byte_val = 8'h3A;
          3'd6:    byte_val = tens_chr[0];
          default: byte_val = ones_chr[0];
        endcase
      end
      default: begin
        byte_rs  = 1'b0;
        byte_val = 8'h00;
      end
    endcase
  end

  assign wr_start = (phase_next == PH_SETUP) &&
                    (state_next == INIT || state_next == ADDR || state_next == CHARS);

  // Bus outputs are registered; rs/data only change at a transaction's setup cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      e_reg    <= 1'b0;
      rs_reg   <= 1'b0;
      data_reg <= 8'h00;
    end else begin
      e_reg <= (phase_next == PH_PULSE);
      if (wr_start) begin
        rs_reg   <= byte_rs;
        data_reg <= byte_val;
      end
    end
  end

  assign lcd.lcd_e    = e_reg;
  assign lcd.lcd_rs   = rs_reg;
  assign lcd.lcd_rw   = 1'b0;
  assign lcd.lcd_data = data_reg;
  assign busy         = (state_reg != IDLE);

endmodule

// File: doc/lcd_clock_display.md
Name: lcd_clock_display

Overview:
- Downstream consumer of the hours/minutes/seconds time counter.
- Takes binary sec/min/hour values and drives an HD44780-compatible character LCD in 8-bit write-only mode.
- After a power-up init sequence, it writes "HH:MM:SS" to line 1, column 0, whenever the displayed time differs from the inputs.
- All LCD timing is derived from clock-cycle counts.

Parameters:
- E_PULSE, 12: cycles lcd_e is held high per write.
- CMD_WAIT, 2000: idle cycles after every write except clear.
- CLR_WAIT, 82000: idle cycles after the clear-display command.
- PWRUP_WAIT, 750000: cycles waited after reset release before the first write.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- sec  in  6  seconds, binary, 0..63 accepted.
- min  in  6  minutes, binary, 0..63 accepted.
- hour  in  6  hours, binary, 0..63 accepted.
- lcd_e  out  1  LCD enable strobe.
- lcd_rs  out  1  register select: 0 = command, 1 = data.
- lcd_rw  out  1  read/write select; constant 0.
- lcd_data  out  8  LCD data bus.
- busy  out  1  1 whenever the FSM is not in IDLE.

Behaviour:
- Interface: one clock (clock); reset is asynchronous and active-high (reset). Asserting reset immediately forces:
  - lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=8'h00, busy=1.
  - FSM=PWRUP, wait counter cleared, "shown" flag cleared.
- Write transaction, always 1+E_PULSE+WAIT cycles:
  - Cycle 0 (setup): lcd_rs/lcd_data driven, lcd_e=0.
  - Cycles 1..E_PULSE: lcd_e=1.
  - Then WAIT cycles with lcd_e=0. WAIT is CLR_WAIT for command 8'h01, CMD_WAIT otherwise.
  - lcd_rs/lcd_data stay stable from the setup cycle until the next transaction's setup cycle.
- FSM states:
  - PWRUP: count PWRUP_WAIT cycles, then go to INIT.
  - INIT: commands with rs=0, in order: 38, 38, 38 (8-bit, 2-line), 0C (display on, cursor off), 01 (clear), 06 (entry increment). Then go to IDLE.
  - IDLE: busy=0. If shown=0, or {hour,min,sec} differs from the last-displayed snapshot: latch the inputs into the snapshot and go to ADDR on the next cycle.
  - ADDR: command 8'h80 (rs=0). Then go to CHARS.
  - CHARS: 8 data writes (rs=1): H10, H1, 3A, M10, M1, 3A, S10, S1. After the last write's wait: set shown=1, go to IDLE.
- Digit conversion:
  - Tens = value/10, units = value%10. Must be correct for every value 0..63; no clamping (63 displays "63").
  - Character code = 8'h30 + digit.
- Snapshot rules:
  - Inputs are sampled only at the IDLE->ADDR transition.
  - Input changes during a frame do not alter that frame. They are picked up by the comparison on return to IDLE.
- busy timing:
  - busy rises the cycle after the update decision in IDLE.
  - busy falls in the cycle after the last wait of a frame completes.
- Reset mid-transaction, including while lcd_e=1: outputs drop immediately. The full PWRUP+INIT sequence restarts after release.
- Counters must be wide enough for PWRUP_WAIT. Each wait counter reloads at every transaction start.

Test Plan:
1. Parameters E_PULSE=2, CMD_WAIT=4, CLR_WAIT=10, PWRUP_WAIT=20; inputs 0; release reset.
   -> First lcd_e rise at cycle 21.
   -> Captured bytes on lcd_e fall: 38,38,38,0C,01,06 (rs=0); 80 (rs=0); 30,30,3A,30,30,3A,30,30 (rs=1).
   -> busy=0 afterwards. lcd_rw=0 throughout.
2. hour=23, min=59, sec=59 held.
   -> Frame 80, 32,33,3A,35,39,3A,35,39.
   -> No further lcd_e pulses for 1000 cycles while inputs are steady.
3. Idle showing 00:00:05; set sec=6.
   -> busy=1 within 2 cycles.
   -> Frame 80, 30,30,3A,30,30,3A,30,36.
4. During the 3rd character of a frame for 12:34:56, change sec to 57.
   -> That frame completes as 31,32,3A,33,34,3A,35,36.
   -> A second frame follows immediately ending 35,37.
5. Timing check.
   -> lcd_e high exactly E_PULSE cycles.
   -> Rise-to-rise spacing 1+E_PULSE+CMD_WAIT = 7 cycles, except after command 01, where it is 13 cycles.
   -> lcd_data/lcd_rs stable throughout every lcd_e high window.
6. Assert reset while lcd_e=1 mid-frame.
   -> Same cycle: lcd_e=0, lcd_data=00, busy=1.
   -> After release: wait 20 cycles, then the sequence restarts with 38, and the full frame is rewritten even with unchanged inputs.
   -> With hour=63 the frame shows 36,33.
